// File: rtl/cpu_ctrl_pkg.sv
// Shared constants for the single-bus CPU control sequencer: opcodes, ALU codes,
// FSM states, instruction classes and fault codes.
package cpu_ctrl_pkg;

    localparam logic [4:0] OPC_ADD  = 5'b00011;
    localparam logic [4:0] OPC_SUB  = 5'b00100;
    localparam logic [4:0] OPC_AND  = 5'b00101;
    localparam logic [4:0] OPC_OR   = 5'b00110;
    localparam logic [4:0] OPC_SHR  = 5'b00111;
    localparam logic [4:0] OPC_SHRA = 5'b01000;
    localparam logic [4:0] OPC_SHL  = 5'b01001;
    localparam logic [4:0] OPC_ROR  = 5'b01010;
    localparam logic [4:0] OPC_ROL  = 5'b01011;
    localparam logic [4:0] OPC_MUL  = 5'b01111;
    localparam logic [4:0] OPC_DIV  = 5'b10000;
    localparam logic [4:0] OPC_NEG  = 5'b10001;
    localparam logic [4:0] OPC_NOT  = 5'b10010;
    localparam logic [4:0] OPC_NOP  = 5'b11010;
    localparam logic [4:0] OPC_HALT = 5'b11011;

    localparam logic [3:0] CTRL_ALU_PASS = 4'd0;
    localparam logic [3:0] CTRL_ALU_ADD  = 4'd1;
    localparam logic [3:0] CTRL_ALU_SUB  = 4'd2;
    localparam logic [3:0] CTRL_ALU_AND  = 4'd3;
    localparam logic [3:0] CTRL_ALU_OR   = 4'd4;
    localparam logic [3:0] CTRL_ALU_SHR  = 4'd5;
    localparam logic [3:0] CTRL_ALU_SHRA = 4'd6;
    localparam logic [3:0] CTRL_ALU_SHL  = 4'd7;
    localparam logic [3:0] CTRL_ALU_ROR  = 4'd8;
    localparam logic [3:0] CTRL_ALU_ROL  = 4'd9;
    localparam logic [3:0] CTRL_ALU_MUL  = 4'd10;
    localparam logic [3:0] CTRL_ALU_DIV  = 4'd11;
    localparam logic [3:0] CTRL_ALU_NEG  = 4'd12;
    localparam logic [3:0] CTRL_ALU_NOT  = 4'd13;

    localparam logic [1:0] FAULT_NONE    = 2'd0;
    localparam logic [1:0] FAULT_ILLEGAL = 2'd1;
    localparam logic [1:0] FAULT_TIMEOUT = 2'd2;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_T0        = 4'd1,
        ST_T1        = 4'd2,
        ST_T2        = 4'd3,
        ST_T3        = 4'd4,
        ST_T4        = 4'd5,
        ST_T5        = 4'd6,
        ST_T6        = 4'd7,
        ST_HALT      = 4'd8,
`ifdef CTRL_SINGLE_STEP_EN
        ST_FAULT     = 4'd9,
        ST_STEP_WAIT = 4'd10
`else
        ST_FAULT     = 4'd9
`endif
    } ctrl_state_t;

    typedef enum logic [2:0] {
        CLS_TWO_OP  = 3'd0,
        CLS_UNARY   = 3'd1,
        CLS_MULDIV  = 3'd2,
        CLS_NOP     = 3'd3,
        CLS_HALT    = 3'd4,
        CLS_ILLEGAL = 3'd5
    } instr_class_t;

endpackage

// File: rtl/cpu_opcode_decode.sv
// Combinational opcode decode: 5-bit opcode field to instruction class and ALU code.
module cpu_opcode_decode
    import cpu_ctrl_pkg::*;
(
    input  logic [4:0]   opcode,
    output instr_class_t instr_class,
    output logic [3:0]   alu_op
);

    always_comb begin
        instr_class = CLS_ILLEGAL;
        alu_op      = CTRL_ALU_PASS;
        case (opcode)
            OPC_ADD:  begin instr_class = CLS_TWO_OP; alu_op = CTRL_ALU_ADD;  end
            OPC_SUB:  begin instr_class = CLS_TWO_OP; alu_op = CTRL_ALU_SUB;  end
            OPC_AND:  begin instr_class = CLS_TWO_OP; alu_op = CTRL_ALU_AND;  end
            OPC_OR:   begin instr_class = CLS_TWO_OP; alu_op = CTRL_ALU_OR;   end
            OPC_SHR:  begin instr_class = CLS_TWO_OP; alu_op = CTRL_ALU_SHR;  end
            OPC_SHRA: begin instr_class = CLS_TWO_OP; alu_op = CTRL_ALU_SHRA; end
            OPC_SHL:  begin instr_class = CLS_TWO_OP; alu_op = CTRL_ALU_SHL;  end
            OPC_ROR:  begin instr_class = CLS_TWO_OP; alu_op = CTRL_ALU_ROR;  end
            OPC_ROL:  begin instr_class = CLS_TWO_OP; alu_op = CTRL_ALU_ROL;  end
            OPC_MUL:  begin instr_class = CLS_MULDIV; alu_op = CTRL_ALU_MUL;  end
            OPC_DIV:  begin instr_class = CLS_MULDIV; alu_op = CTRL_ALU_DIV;  end
            OPC_NEG:  begin instr_class = CLS_UNARY;  alu_op = CTRL_ALU_NEG;  end
            OPC_NOT:  begin instr_class = CLS_UNARY;  alu_op = CTRL_ALU_NOT;  end
            OPC_NOP:  instr_class = CLS_NOP;
            OPC_HALT: instr_class = CLS_HALT;
            default:  instr_class = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/cpu_control_sequencer.sv
// Hardwired Moore control unit for the single-bus CPU datapath (fetch, decode, ALU sequencing).
// Define CTRL_SINGLE_STEP_EN to add the step input and the STEP_WAIT park state.
module cpu_control_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int IR_WIDTH    = 32,
    parameter int OPC_MSB     = 31,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic                clock,
    input  logic                clear,
`ifdef CTRL_SINGLE_STEP_EN
    input  logic                step,
`endif
    input  logic                run,
    input  logic                mem_ready,
    input  logic [IR_WIDTH-1:0] IR,
    output logic                PCout,
    output logic                Zlowout,
    output logic                Zhighout,
    output logic                MDRout,
    output logic                MARin,
    output logic                MDRin,
    output logic                IRin,
    output logic                Yin,
    output logic                Zin,
    output logic                PCin,
    output logic                LOin,
    output logic                HIin,
    output logic                IncPC,
    output logic                Read,
    output logic                Gra,
    output logic                Grb,
    output logic                Grc,
    output logic                Rin,
    output logic                Rout,
    output logic [3:0]          alu_op,
    output logic                done,
    output logic                halted,
    output logic [1:0]          fault
);

    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

    ctrl_state_t  state;
    ctrl_state_t  after_done;
    instr_class_t op_class;
    instr_class_t dec_class;
    logic [3:0]   op_alu;
    logic [3:0]   dec_alu;
    logic [1:0]   fault_r;
    logic [CNT_W-1:0] tmo_cnt;
    logic         start_ok;
    logic         unused_ir;

    assign unused_ir = ^IR;

    cpu_opcode_decode u_decode (
        .opcode      (IR[OPC_MSB -: 5]),
        .instr_class (dec_class),
        .alu_op      (dec_alu)
    );

    always_comb begin
`ifdef CTRL_SINGLE_STEP_EN
        after_done = ST_STEP_WAIT;
        start_ok   = run && step;
`else
        after_done = run ? ST_T0 : ST_IDLE;
        start_ok   = run;
`endif
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            state    <= ST_IDLE;
            op_class <= CLS_NOP;
            op_alu   <= CTRL_ALU_PASS;
            fault_r  <= FAULT_NONE;
            tmo_cnt  <= '0;
        end else begin
            case (state)
                ST_IDLE: if (start_ok) state <= ST_T0;
                ST_T0: begin
                    state   <= ST_T1;
                    tmo_cnt <= '0;
                end
                // The MEM_TIMEOUT-th consecutive stalled T1 cycle is the last one.
                ST_T1: begin
                    if (mem_ready) begin
                        state   <= ST_T2;
                        tmo_cnt <= '0;
                    end else if (tmo_cnt == CNT_W'(MEM_TIMEOUT - 1)) begin
                        state   <= ST_FAULT;
                        fault_r <= FAULT_TIMEOUT;
                    end else begin
                        tmo_cnt <= tmo_cnt + CNT_W'(1);
                    end
                end
                ST_T2: begin
                    op_class <= dec_class;
                    op_alu   <= dec_alu;
                    case (dec_class)
                        CLS_HALT:    state <= ST_HALT;
                        CLS_ILLEGAL: begin
                            state   <= ST_FAULT;
                            fault_r <= FAULT_ILLEGAL;
                        end
                        default:     state <= ST_T3;
                    endcase
                end
                ST_T3: state <= (op_class == CLS_NOP)    ? after_done : ST_T4;
                ST_T4: state <= (op_class == CLS_UNARY)  ? after_done : ST_T5;
                ST_T5: state <= (op_class == CLS_TWO_OP) ? after_done : ST_T6;
                ST_T6: state <= after_done;
`ifdef CTRL_SINGLE_STEP_EN
                ST_STEP_WAIT: if (step && run) state <= ST_T0;
`endif
                ST_HALT:  state <= ST_HALT;
                ST_FAULT: state <= ST_FAULT;
                default:  state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        {PCout, Zlowout, Zhighout, MDRout} = '0;
        {MARin, MDRin, IRin, Yin, Zin, PCin, LOin, HIin, IncPC, Read} = '0;
        {Gra, Grb, Grc, Rin, Rout} = '0;
        alu_op = CTRL_ALU_PASS;
        done   = 1'b0;
        halted = (state == ST_HALT) || (state == ST_FAULT);
        fault  = fault_r;
        case (state)
            ST_T0: {PCout, MARin, IncPC, Zin} = '1;
            ST_T1: {Zlowout, PCin, Read, MDRin} = '1;
            ST_T2: {MDRout, IRin} = '1;
            ST_T3: begin
                case (op_class)
                    CLS_TWO_OP: {Grb, Rout, Yin} = '1;
                    CLS_UNARY: begin
                        {Grb, Rout, Zin} = '1;
                        alu_op = op_alu;
                    end
                    CLS_MULDIV: {Gra, Rout, Yin} = '1;
                    default:    done = 1'b1;
                endcase
            end
            ST_T4: begin
                case (op_class)
                    CLS_UNARY: {Zlowout, Gra, Rin, done} = '1;
                    CLS_MULDIV: begin
                        {Grb, Rout, Zin} = '1;
                        alu_op = op_alu;
                    end
                    default: begin
                        {Grc, Rout, Zin} = '1;
                        alu_op = op_alu;
                    end
                endcase
            end
            ST_T5: begin
                if (op_class == CLS_MULDIV) {Zlowout, LOin} = '1;
                else                        {Zlowout, Gra, Rin, done} = '1;
            end
            ST_T6: {Zhighout, HIin, done} = '1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cpu_control_sequencer.sv
// Randomized self-checking bench for cpu_control_sequencer against a T-state table model.
module tb_cpu_control_sequencer;

    logic        clock = 1'b0;
    logic        clear, run, mem_ready;
    logic [31:0] IR;
    logic        PCout, Zlowout, Zhighout, MDRout, MARin, MDRin, IRin, Yin, Zin, PCin;
    logic        LOin, HIin, IncPC, Read, Gra, Grb, Grc, Rin, Rout, done, halted;
    logic [3:0]  alu_op;
    logic [1:0]  fault;
`ifdef CTRL_SINGLE_STEP_EN
    logic        step;
`endif

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    bit          gap_pending = 1'b0;
    logic [26:0] exp_q[$];

    localparam logic [26:0] M_PCOUT  = 27'd1 << 26;
    localparam logic [26:0] M_ZLOW   = 27'd1 << 25;
    localparam logic [26:0] M_ZHIGH  = 27'd1 << 24;
    localparam logic [26:0] M_MDROUT = 27'd1 << 23;
    localparam logic [26:0] M_MARIN  = 27'd1 << 22;
    localparam logic [26:0] M_MDRIN  = 27'd1 << 21;
    localparam logic [26:0] M_IRIN   = 27'd1 << 20;
    localparam logic [26:0] M_YIN    = 27'd1 << 19;
    localparam logic [26:0] M_ZIN    = 27'd1 << 18;
    localparam logic [26:0] M_PCIN   = 27'd1 << 17;
    localparam logic [26:0] M_LOIN   = 27'd1 << 16;
    localparam logic [26:0] M_HIIN   = 27'd1 << 15;
    localparam logic [26:0] M_INCPC  = 27'd1 << 14;
    localparam logic [26:0] M_READ   = 27'd1 << 13;
    localparam logic [26:0] M_GRA    = 27'd1 << 12;
    localparam logic [26:0] M_GRB    = 27'd1 << 11;
    localparam logic [26:0] M_GRC    = 27'd1 << 10;
    localparam logic [26:0] M_RIN    = 27'd1 << 9;
    localparam logic [26:0] M_ROUT   = 27'd1 << 8;
    localparam logic [26:0] M_DONE   = 27'd1 << 7;
    localparam logic [26:0] M_HALTED = 27'd1 << 6;
    localparam logic [26:0] M_F_ILL  = 27'd1 << 4;
    localparam logic [26:0] M_F_TMO  = 27'd2 << 4;

    localparam logic [26:0] V_T0 = M_PCOUT | M_MARIN | M_INCPC | M_ZIN;
    localparam logic [26:0] V_T1 = M_ZLOW | M_PCIN | M_READ | M_MDRIN;
    localparam logic [26:0] V_T2 = M_MDROUT | M_IRIN;

    logic [4:0] legal_ops [0:13] = '{5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111,
                                     5'b01000, 5'b01001, 5'b01010, 5'b01011, 5'b01111,
                                     5'b10000, 5'b10001, 5'b10010, 5'b11010};
    logic [4:0] illegal_ops [0:16] = '{5'b00000, 5'b00001, 5'b00010, 5'b01100, 5'b01101,
                                       5'b01110, 5'b10011, 5'b10100, 5'b10101, 5'b10110,
                                       5'b10111, 5'b11000, 5'b11001, 5'b11100, 5'b11101,
                                       5'b11110, 5'b11111};

    always #5 clock = ~clock;

    cpu_control_sequencer #(
        .IR_WIDTH    (32),
        .OPC_MSB     (31),
        .MEM_TIMEOUT (255)
    ) dut (
        .clock     (clock),
        .clear     (clear),
`ifdef CTRL_SINGLE_STEP_EN
        .step      (step),
`endif
        .run       (run),
        .mem_ready (mem_ready),
        .IR        (IR),
        .PCout     (PCout),
        .Zlowout   (Zlowout),
        .Zhighout  (Zhighout),
        .MDRout    (MDRout),
        .MARin     (MARin),
        .MDRin     (MDRin),
        .IRin      (IRin),
        .Yin       (Yin),
        .Zin       (Zin),
        .PCin      (PCin),
        .LOin      (LOin),
        .HIin      (HIin),
        .IncPC     (IncPC),
        .Read      (Read),
        .Gra       (Gra),
        .Grb       (Grb),
        .Grc       (Grc),
        .Rin       (Rin),
        .Rout      (Rout),
        .alu_op    (alu_op),
        .done      (done),
        .halted    (halted),
        .fault     (fault)
    );

    function automatic logic [26:0] obs();
        return {PCout, Zlowout, Zhighout, MDRout, MARin, MDRin, IRin, Yin, Zin, PCin,
                LOin, HIin, IncPC, Read, Gra, Grb, Grc, Rin, Rout, done, halted, fault, alu_op};
    endfunction

    // 0 two-operand, 1 unary, 2 mul/div, 3 nop, 4 halt, 5 illegal
    function automatic int kind_of(input logic [4:0] opc);
        case (opc)
            5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111,
            5'b01000, 5'b01001, 5'b01010, 5'b01011: return 0;
            5'b10001, 5'b10010: return 1;
            5'b01111, 5'b10000: return 2;
            5'b11010: return 3;
            5'b11011: return 4;
            default:  return 5;
        endcase
    endfunction

    function automatic logic [26:0] alu_of(input logic [4:0] opc);
        case (opc)
            5'b00011: return 27'd1;
            5'b00100: return 27'd2;
            5'b00101: return 27'd3;
            5'b00110: return 27'd4;
            5'b00111: return 27'd5;
            5'b01000: return 27'd6;
            5'b01001: return 27'd7;
            5'b01010: return 27'd8;
            5'b01011: return 27'd9;
            5'b01111: return 27'd10;
            5'b10000: return 27'd11;
            5'b10001: return 27'd12;
            5'b10010: return 27'd13;
            default:  return 27'd0;
        endcase
    endfunction

    function automatic void build(input logic [4:0] opc, input int unsigned d);
        logic [26:0] a;
        a = alu_of(opc);
        exp_q.delete();
        if (gap_pending) exp_q.push_back(27'd0);
        exp_q.push_back(V_T0);
        for (int unsigned j = 0; j <= d; j++) exp_q.push_back(V_T1);
        exp_q.push_back(V_T2);
        case (kind_of(opc))
            0: begin
                exp_q.push_back(M_GRB | M_ROUT | M_YIN);
                exp_q.push_back(M_GRC | M_ROUT | M_ZIN | a);
                exp_q.push_back(M_ZLOW | M_GRA | M_RIN | M_DONE);
            end
            1: begin
                exp_q.push_back(M_GRB | M_ROUT | M_ZIN | a);
                exp_q.push_back(M_ZLOW | M_GRA | M_RIN | M_DONE);
            end
            2: begin
                exp_q.push_back(M_GRA | M_ROUT | M_YIN);
                exp_q.push_back(M_GRB | M_ROUT | M_ZIN | a);
                exp_q.push_back(M_ZLOW | M_LOIN);
                exp_q.push_back(M_ZHIGH | M_HIIN | M_DONE);
            end
            3: exp_q.push_back(M_DONE);
            4: repeat (3) exp_q.push_back(M_HALTED);
            default: repeat (3) exp_q.push_back(M_HALTED | M_F_ILL);
        endcase
    endfunction

    // Runs one instruction; on entry the next edge must start the fetch (or the step gap).
    task automatic run_instr(input logic [4:0] opc, input int unsigned d, input bit run_after,
                             input string name);
        int unsigned t1_seen = 0;
        int unsigned bus;
        int unsigned nsel;
        build(opc, d);
        IR  = {opc, 27'($urandom)};
        run = 1'b1;
        for (int i = 0; i < exp_q.size(); i++) begin
            @(posedge clock); #1;
            n_checks++;
            if (obs() !== exp_q[i])
                $display("FAIL %s cycle %0d: outputs %h, expected %h", name, i, obs(), exp_q[i]);
            else n_pass++;
            bus  = 32'(PCout) + 32'(Zlowout) + 32'(Zhighout) + 32'(MDRout);
            nsel = 32'(Gra) + 32'(Grb) + 32'(Grc);
            n_checks++;
            if (bus > 1 || ((Rin || Rout) && nsel != 1))
                $display("FAIL %s_exclusive cycle %0d: bus drivers %0d, selects %0d, required bus<=1 and one select",
                         name, i, bus, nsel);
            else n_pass++;
            if (exp_q[i] & M_READ) begin
                t1_seen++;
                mem_ready = (t1_seen > d);
            end else begin
                mem_ready = 1'($urandom);
            end
            if (i == exp_q.size() - 1) run = run_after;
            else if (exp_q[i] == 27'd0) run = 1'b1;
            else run = 1'($urandom);
        end
`ifdef CTRL_SINGLE_STEP_EN
        gap_pending = (kind_of(opc) < 4);
`else
        gap_pending = 1'b0;
`endif
    endtask

    task automatic test_reset();
        for (int k = 0; k < 3; k++) begin
            clear = 1'b1; run = 1'($urandom); mem_ready = 1'($urandom); IR = $urandom;
            @(posedge clock); #1;
            n_checks++;
            if (obs() !== 27'd0) $display("FAIL reset_%0d: outputs %h, expected 0", k, obs());
            else n_pass++;
        end
        clear = 1'b0; run = 1'b0;
        @(posedge clock); #1;
        n_checks++;
        if (obs() !== 27'd0) $display("FAIL idle_hold: outputs %h, expected 0", obs());
        else n_pass++;
        gap_pending = 1'b0;
    endtask

    task automatic test_add();
        run_instr(5'b00011, 0, 1'b0, "add");
        @(posedge clock); #1;
        n_checks++;
        if (obs() !== 27'd0) $display("FAIL add_after_done: outputs %h, expected 0", obs());
        else n_pass++;
        gap_pending = 1'b0;
    endtask

    task automatic test_and_delay();
        IR = 32'h28918000;
        run_instr(5'b00101, 3, 1'b0, "and_delay");
        @(posedge clock); #1;
        gap_pending = 1'b0;
    endtask

    task automatic test_mul_nop();
        run_instr(5'b01111, 0, 1'b1, "mul");
        run_instr(5'b11010, 0, 1'b1, "nop");
        run_instr(5'b10001, 0, 1'b0, "neg");
        @(posedge clock); #1;
        gap_pending = 1'b0;
    endtask

    task automatic test_random_mix();
        for (int k = 0; k < 24; k++) begin
            logic [4:0]  opc;
            bit          ra;
            int unsigned d;
            opc = legal_ops[$urandom_range(0, 13)];
            d   = $urandom_range(0, 4);
            ra  = 1'($urandom);
            run_instr(opc, d, ra, $sformatf("mix%0d_op%b", k, opc));
            if (!ra) begin
                repeat ($urandom_range(1, 3)) begin
                    @(posedge clock); #1;
                    n_checks++;
                    if (obs() !== 27'd0) $display("FAIL mix%0d_idle: outputs %h, expected 0", k, obs());
                    else n_pass++;
                    mem_ready = 1'($urandom);
                end
                gap_pending = 1'b0;
            end
        end
        run = 1'b0;
        @(posedge clock); #1;
        gap_pending = 1'b0;
    endtask

    task automatic test_halt_fault();
        for (int k = 0; k < 5; k++) begin
            logic [4:0] opc;
            if (k == 0)      opc = 5'b11011;
            else if (k == 1) opc = 5'b11111;
            else             opc = illegal_ops[$urandom_range(0, 16)];
            run_instr(opc, $urandom_range(0, 2), 1'b1, $sformatf("stop_op%b", opc));
            clear = 1'b1;
            @(posedge clock); #1;
            clear = 1'b0; run = 1'b0;
            n_checks++;
            if (obs() !== 27'd0) $display("FAIL stop_clear_op%b: outputs %h, expected 0", opc, obs());
            else n_pass++;
            gap_pending = 1'b0;
        end
    endtask

    task automatic test_timeout();
        int unsigned cnt = 0;
        IR = {5'b00011, 27'($urandom)};
        run = 1'b1; mem_ready = 1'b0;
        @(posedge clock); #1;
        n_checks++;
        if (obs() !== V_T0) $display("FAIL timeout_t0: outputs %h, expected %h", obs(), V_T0);
        else n_pass++;
        for (int c = 0; c < 1000; c++) begin
            @(posedge clock); #1;
            if (Read) cnt++;
            else break;
        end
        n_checks++;
        if (cnt != 255) $display("FAIL timeout_count: T1 cycles %0d, expected 255", cnt);
        else n_pass++;
        n_checks++;
        if (obs() !== (M_HALTED | M_F_TMO))
            $display("FAIL timeout_fault: outputs %h, expected %h", obs(), M_HALTED | M_F_TMO);
        else n_pass++;
        mem_ready = 1'b1;
        @(posedge clock); #1;
        n_checks++;
        if (fault !== 2'd2) $display("FAIL timeout_sticky: fault %0d, expected 2", fault);
        else n_pass++;
        clear = 1'b1;
        @(posedge clock); #1;
        clear = 1'b0; run = 1'b0;
        n_checks++;
        if (obs() !== 27'd0) $display("FAIL timeout_clear: outputs %h, expected 0", obs());
        else n_pass++;
        gap_pending = 1'b0;
    endtask

    task automatic test_clear_mid_t1();
        IR = {5'b01111, 27'($urandom)};
        run = 1'b1; mem_ready = 1'b0;
        @(posedge clock);
        @(posedge clock);
        repeat ($urandom_range(0, 10)) @(posedge clock);
        #1;
        n_checks++;
        if (Read !== 1'b1) $display("FAIL midt1_read: Read %b, expected 1", Read);
        else n_pass++;
        clear = 1'b1;
        @(posedge clock); #1;
        clear = 1'b0; run = 1'b0; mem_ready = 1'b1;
        n_checks++;
        if (obs() !== 27'd0) $display("FAIL midt1_clear: outputs %h, expected 0", obs());
        else n_pass++;
        @(posedge clock); #1;
        n_checks++;
        if (obs() !== 27'd0) $display("FAIL midt1_idle: outputs %h, expected 0", obs());
        else n_pass++;
        gap_pending = 1'b0;
    endtask

`ifdef CTRL_SINGLE_STEP_EN
    task automatic test_single_step();
        step = 1'b0; run = 1'b1;
        @(posedge clock); #1;
        n_checks++;
        if (obs() !== 27'd0) $display("FAIL step_idle_wait: outputs %h, expected 0", obs());
        else n_pass++;
        step = 1'b1;
        gap_pending = 1'b0;
        run_instr(5'b11010, 0, 1'b1, "step_nop1");
        step = 1'b0;
        repeat (3) begin
            @(posedge clock); #1;
            n_checks++;
            if (obs() !== 27'd0) $display("FAIL step_park: outputs %h, expected 0", obs());
            else n_pass++;
        end
        step = 1'b1;
        gap_pending = 1'b0;
        run_instr(5'b11010, 0, 1'b0, "step_nop2");
        @(posedge clock); #1;
        gap_pending = 1'b0;
    endtask
`endif

    initial begin
        clear = 1'b1; run = 1'b0; mem_ready = 1'b0; IR = '0;
`ifdef CTRL_SINGLE_STEP_EN
        step = 1'b1;
`endif
        test_reset();
        IR = 32'h18918000;
        test_add();
        test_and_delay();
        test_mul_nop();
        test_random_mix();
        test_halt_fault();
        test_timeout();
        test_clear_mid_t1();
`ifdef CTRL_SINGLE_STEP_EN
        test_single_step();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
